servo_angle_sequencer: RTL and testbench
========================================

Name: servo_angle_sequencer

Overview:
- Upstream stage of the servo PWM generator; produces the 16-bit angle word (degrees, 0..180) that the PWM stage converts to pulse width.
- Sweeps the IR servo across its range, locks when the IR receiver reports a hit, and accepts manual target commands.
- Angle changes are rate-limited: at most one step per PWM frame (~20 ms), so the servo never receives a jump larger than STEP.

Parameters:
- FRAME_CYCLES, 2_000_000, clk cycles per update frame (20 ms at 100 MHz); matches the PWM period.
- ANGLE_MIN, 0, lower angle bound (degrees).
- ANGLE_MAX, 180, upper angle bound (degrees).
- ANGLE_HOME, 90, reset/idle angle.
- STEP, 2, max angle change per frame.
- LOST_FRAMES, 25, consecutive frames without detect before LOCK falls back to SWEEP.
- DWELL_FRAMES, 10, bound dwell length; used only with SWEEP_DWELL_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- ir_detect  in  1  IR hit, already synchronous to clk; sampled only on frame_tick cycles.
- cmd_valid  in  1  manual target offered.
- cmd_angle  in  16  manual target, degrees.
- cmd_ready  out  1  command can be accepted.
- angle  out  16  registered angle to PWM stage.
- frame_tick  out  1  one-cycle pulse per frame.
- state  out  2  00 IDLE, 01 SWEEP, 10 LOCK, 11 MANUAL.
- locked  out  1  high while in LOCK.

Behaviour:
- Reset values: angle=ANGLE_HOME, state=IDLE, direction=up, frame counter=0, lost counter=0, target=ANGLE_HOME, frame_tick=0, cmd_ready=0, locked=0.
- Frame counter runs freely 0..FRAME_CYCLES-1 in every state and wraps to 0. frame_tick is high during the cycle the counter equals FRAME_CYCLES-1.
- angle updates only on a tick cycle. The new value is visible on the next cycle. Arithmetic is done at 17 bits, then clamped to [ANGLE_MIN, ANGLE_MAX].
- cmd_ready = enable && state != IDLE.
- Handshake: a command is accepted on any cycle with cmd_valid && cmd_ready. cmd_angle is clamped to [MIN, MAX], stored as the target, and state moves to MANUAL on the next cycle. Acceptance does not wait for a tick.
- Priority, highest first: rst > enable=0 > command accept > ir_detect > stepping.
- IDLE: on each tick, angle slews toward ANGLE_HOME by at most STEP. When the remaining distance is < STEP, the step lands exactly on HOME. enable=1 moves to SWEEP on the next cycle, starting from the current angle.
- Any state with enable=0: go to IDLE on the next cycle. angle holds (no jump), then slews home. Direction is preserved.
- SWEEP, on tick:
  - ir_detect=1: go to LOCK, no step that tick, lost counter=0.
  - Otherwise angle += STEP (up) or -= STEP (down).
  - If the result would reach or cross a bound: angle=bound, direction reverses.
- LOCK: angle held. On each tick, ir_detect=1 clears the lost counter; ir_detect=0 increments it. When the counter reaches LOST_FRAMES, go to SWEEP with direction preserved and the counter cleared.
- MANUAL: on each tick, angle slews toward the target by at most STEP, landing exactly. Stays in MANUAL (ir_detect ignored) until enable=0. A new command retargets immediately. A command equal to the current angle causes no motion.
- Reset mid-slew or mid-frame: everything returns to reset values on the next cycle. The counter restarts at 0.

Optional Feature:
- Macro: SWEEP_DWELL_EN.
- Defined: in SWEEP, after angle reaches a bound, it holds for DWELL_FRAMES ticks before stepping in the reversed direction. ir_detect is still honoured during the dwell. Dwell count is cleared on state exit.
- Undefined: stepping away from the bound begins on the very next tick. No dwell logic.

Test Plan (FRAME_CYCLES=10, STEP=2, LOST_FRAMES=3, macro undefined unless noted):
- Reset, enable=0 for 50 cycles -> angle=90, state=00, frame_tick pulses every 10 cycles, cmd_ready=0.
- enable=1 -> state=01; angle 92, 94, ... on successive ticks; 180 then 178; 0 then 2. angle never leaves [0,180].
- In SWEEP at 120, ir_detect=1 on tick -> state=10, locked=1, angle stays 120. ir_detect=0 for 3 ticks -> state=01, angle resumes 122.
- cmd_angle=200 accepted while angle=170 -> target clamps to 180, state=11, angle 172..180 one step per tick. cmd_angle=95 -> angle ramps down, ending exactly at 95.
- enable dropped at angle=37 -> state=00, angle 39, 41, ... ending exactly at 90. rst mid-ramp -> angle=90, counter restarts.
- SWEEP_DWELL_EN, DWELL_FRAMES=2 -> angle holds at 180 for 2 ticks, then 178.

Source files
------------

// File: rtl/servo_cmd_if.sv
// Manual-target command handshake between a command source and the servo angle sequencer.
interface servo_cmd_if;
   logic        cmd_valid;
   logic [15:0] cmd_angle;
   logic        cmd_ready;

   modport master (output cmd_valid, output cmd_angle, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_angle, output cmd_ready);
endinterface

// File: rtl/servo_angle_sequencer.sv
// Rate-limited servo angle sequencer: sweep, lock on IR hit, manual targets, slew home when idle.
// Optional macro SWEEP_DWELL_EN: hold at each sweep bound for DWELL_FRAMES ticks before reversing.
//
// state  | meaning
// IDLE   | enable low; slew toward ANGLE_HOME one step per frame
// SWEEP  | bounce between ANGLE_MIN and ANGLE_MAX, watch ir_detect
// LOCK   | hold angle while hits keep arriving; LOST_FRAMES misses return to SWEEP
// MANUAL | slew toward the last accepted command target
module servo_angle_sequencer #(
   parameter int unsigned FRAME_CYCLES = 2_000_000,
   parameter int unsigned ANGLE_MIN    = 0,
   parameter int unsigned ANGLE_MAX    = 180,
   parameter int unsigned ANGLE_HOME   = 90,
   parameter int unsigned STEP         = 2,
   parameter int unsigned LOST_FRAMES  = 25
`ifdef SWEEP_DWELL_EN
   ,
   parameter int unsigned DWELL_FRAMES = 10
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        ir_detect,
   servo_cmd_if.slave  cmd,
   output logic [15:0] angle,
   output logic        frame_tick,
   output logic [1:0]  state,
   output logic        locked
);

   localparam int unsigned FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int unsigned LC_W = $clog2(LOST_FRAMES + 1);
   localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAME_CYCLES - 1);
   localparam logic [LC_W-1:0] LOST_LAST = LC_W'(LOST_FRAMES - 1);
   localparam logic [16:0] MIN17  = 17'(ANGLE_MIN);
   localparam logic [16:0] MAX17  = 17'(ANGLE_MAX);
   localparam logic [16:0] HOME17 = 17'(ANGLE_HOME);
   localparam logic [16:0] STEP17 = 17'(STEP);
   localparam logic [15:0] MIN16  = 16'(ANGLE_MIN);
   localparam logic [15:0] MAX16  = 16'(ANGLE_MAX);
   localparam logic [15:0] HOME16 = 16'(ANGLE_HOME);
`ifdef SWEEP_DWELL_EN
   localparam int unsigned DW_W = (DWELL_FRAMES > 0) ? $clog2(DWELL_FRAMES + 1) : 1;
   localparam logic [DW_W-1:0] DWELL_INIT = DW_W'(DWELL_FRAMES);
`endif

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SWEEP  = 2'b01,
      ST_LOCK   = 2'b10,
      ST_MANUAL = 2'b11
   } state_t;

   state_t          st;
   logic [FC_W-1:0] frame_cnt;
   logic [LC_W-1:0] lost_cnt;
   logic            dir_up;
   logic [15:0]     target;
   logic            tick;
   logic            cmd_fire;
   logic [16:0]     angle17;
   logic [16:0]     up17;
   logic [16:0]     dn17;
   logic [16:0]     cmd_clamped;
`ifdef SWEEP_DWELL_EN
   logic [DW_W-1:0] dwell_cnt;
`endif

   function automatic logic [16:0] clamp17(input logic [16:0] v);
      logic [16:0] lo;
      lo = (v <= MIN17) ? MIN17 : v;
      return (lo >= MAX17) ? MAX17 : lo;
   endfunction

   // Move at most STEP toward tgt, landing exactly when closer than a full step.
   function automatic logic [15:0] slew(input logic [16:0] cur, input logic [16:0] tgt);
      logic [16:0] nxt;
      nxt = cur;
      if (cur < tgt)
         nxt = ((tgt - cur) <= STEP17) ? tgt : cur + STEP17;
      else if (cur > tgt)
         nxt = ((cur - tgt) <= STEP17) ? tgt : cur - STEP17;
      nxt = clamp17(nxt);
      return nxt[15:0];
   endfunction

   assign tick          = (frame_cnt == FC_LAST);
   assign frame_tick    = tick;
   assign state         = st;
   assign angle17       = {1'b0, angle};
   assign up17          = angle17 + STEP17;
   assign dn17          = angle17 - STEP17;
   assign cmd_clamped   = clamp17({1'b0, cmd.cmd_angle});
   assign cmd.cmd_ready = enable && (st != ST_IDLE);
   assign cmd_fire      = cmd.cmd_valid && enable && (st != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
         st        <= ST_IDLE;
         angle     <= HOME16;
         target    <= HOME16;
         dir_up    <= 1'b1;
         lost_cnt  <= '0;
         locked    <= 1'b0;
`ifdef SWEEP_DWELL_EN
         dwell_cnt <= '0;
`endif
      end else begin
         frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
`ifdef SWEEP_DWELL_EN
         if (st != ST_SWEEP)
            dwell_cnt <= '0;
`endif
         if (!enable) begin
            st     <= ST_IDLE;
            locked <= 1'b0;
            if (st == ST_IDLE && tick)
               angle <= slew(angle17, HOME17);
         end else if (cmd_fire) begin
            target <= cmd_clamped[15:0];
            st     <= ST_MANUAL;
            locked <= 1'b0;
         end else begin
            case (st)
               ST_IDLE: st <= ST_SWEEP;
               ST_SWEEP: if (tick) begin
                  if (ir_detect) begin
                     st       <= ST_LOCK;
                     locked   <= 1'b1;
                     lost_cnt <= '0;
                  end
`ifdef SWEEP_DWELL_EN
                  else if (dwell_cnt != '0)
                     dwell_cnt <= dwell_cnt - 1'b1;
`endif
                  else if (dir_up) begin
                     if (up17 >= MAX17) begin
                        angle  <= MAX16;
                        dir_up <= 1'b0;
`ifdef SWEEP_DWELL_EN
                        dwell_cnt <= DWELL_INIT;
`endif
                     end else
                        angle <= up17[15:0];
                  end else begin
                     if (angle17 <= MIN17 + STEP17) begin
                        angle  <= MIN16;
                        dir_up <= 1'b1;
`ifdef SWEEP_DWELL_EN
                        dwell_cnt <= DWELL_INIT;
`endif
                     end else
                        angle <= dn17[15:0];
                  end
               end
               ST_LOCK: if (tick) begin
                  if (ir_detect)
                     lost_cnt <= '0;
                  else if (lost_cnt == LOST_LAST) begin
                     st       <= ST_SWEEP;
                     locked   <= 1'b0;
                     lost_cnt <= '0;
                  end else
                     lost_cnt <= lost_cnt + 1'b1;
               end
               ST_MANUAL: if (tick) angle <= slew(angle17, {1'b0, target});
               default: st <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_servo_angle_sequencer.sv
// Scoreboard bench: stimulus queues expected post-tick angle/state/locked, a monitor pops after each frame tick.
module tb_servo_angle_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        ir_detect;
   logic [15:0] angle;
   logic        frame_tick;
   logic [1:0]  state;
   logic        locked;

   int checks = 0;
   int errors = 0;
   logic [18:0] exp_q[$];
   logic tick_seen = 1'b0;

   servo_cmd_if cmd_if();

   servo_angle_sequencer #(
      .FRAME_CYCLES(10),
      .ANGLE_MIN(0),
      .ANGLE_MAX(180),
      .ANGLE_HOME(90),
      .STEP(2),
      .LOST_FRAMES(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .ir_detect(ir_detect),
      .cmd(cmd_if),
      .angle(angle),
      .frame_tick(frame_tick),
      .state(state),
      .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one cycle after every frame tick the new angle is visible.
   always @(negedge clk) begin
      logic [18:0] e;
      if (tick_seen && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("tick_angle", int'(angle), int'(e[18:3]));
         chk("tick_state", int'(state), int'(e[2:1]));
         chk("tick_locked", int'(locked), int'(e[0]));
      end
      tick_seen = frame_tick;
   end

   // Wait for the next tick cycle, present ir for it, and queue what must follow.
   task automatic te(input logic ir, input int a, input int s, input int l);
      int n;
      logic [15:0] a16;
      logic [1:0]  s2;
      n = 0;
      while (frame_tick !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (frame_tick !== 1'b1) chk("tick_timeout", 0, 1);
      ir_detect = ir;
      a16 = a[15:0];
      s2  = s[1:0];
      exp_q.push_back({a16, s2, l[0]});
      @(negedge clk);
   endtask

   task automatic send_cmd(input int v, input int cur);
      repeat (2) @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_angle = v[15:0];
      chk("cmd_ready_high", int'(cmd_if.cmd_ready), 1);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      chk("cmd_state", int'(state), 3);
      chk("cmd_angle_hold", int'(angle), cur);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first;
      int cnt;
      int n;
      rst = 1'b1;
      enable = 1'b0;
      ir_detect = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_angle = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_angle", int'(angle), 90);
      chk("rst_state", int'(state), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_cmd_ready", int'(cmd_if.cmd_ready), 0);
      chk("rst_frame_tick", int'(frame_tick), 0);

      first = -1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         if (frame_tick) begin
            if (first < 0) first = i;
            cnt++;
         end
         @(negedge clk);
      end
      chk("first_tick_cycle", first, 9);
      chk("tick_count_50", cnt, 5);
      chk("idle_angle", int'(angle), 90);
      chk("idle_state", int'(state), 0);
      chk("idle_cmd_ready", int'(cmd_if.cmd_ready), 0);

      enable = 1'b1;
      @(negedge clk);
      chk("sweep_state", int'(state), 1);
      chk("sweep_cmd_ready", int'(cmd_if.cmd_ready), 1);

      for (int a = 92; a <= 180; a += 2) te(1'b0, a, 1, 0);
      for (int a = 178; a >= 0; a -= 2) te(1'b0, a, 1, 0);
      for (int a = 2; a <= 120; a += 2) te(1'b0, a, 1, 0);

      te(1'b1, 120, 2, 1);
      te(1'b0, 120, 2, 1);
      te(1'b0, 120, 2, 1);
      te(1'b0, 120, 1, 0);
      te(1'b0, 122, 1, 0);

      // ir between ticks must be ignored
      ir_detect = 1'b1;
      @(negedge clk);
      ir_detect = 1'b0;
      @(negedge clk);
      chk("ir_off_tick_state", int'(state), 1);

      for (int a = 124; a <= 170; a += 2) te(1'b0, a, 1, 0);

      send_cmd(200, 170);
      te(1'b0, 172, 3, 0);
      te(1'b1, 174, 3, 0);
      te(1'b0, 176, 3, 0);
      te(1'b0, 178, 3, 0);
      te(1'b0, 180, 3, 0);
      te(1'b0, 180, 3, 0);

      send_cmd(95, 180);
      for (int a = 178; a >= 96; a -= 2) te(1'b0, a, 3, 0);
      te(1'b0, 95, 3, 0);
      te(1'b0, 95, 3, 0);

      send_cmd(95, 95);
      te(1'b0, 95, 3, 0);

      send_cmd(37, 95);
      for (int a = 93; a >= 37; a -= 2) te(1'b0, a, 3, 0);

      enable = 1'b0;
      @(negedge clk);
      chk("disable_state", int'(state), 0);
      chk("disable_cmd_ready", int'(cmd_if.cmd_ready), 0);
      chk("disable_angle_hold", int'(angle), 37);
      for (int a = 39; a <= 89; a += 2) te(1'b0, a, 0, 0);
      te(1'b0, 90, 0, 0);
      te(1'b0, 90, 0, 0);

      enable = 1'b1;
      @(negedge clk);
      chk("reenable_state", int'(state), 1);
      te(1'b0, 92, 1, 0);
      te(1'b0, 94, 1, 0);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_angle", int'(angle), 90);
      chk("midrst_state", int'(state), 0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_frame_tick", int'(frame_tick), 0);
      chk("midrst_cmd_ready", int'(cmd_if.cmd_ready), 0);
      n = 0;
      while (frame_tick !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_first_tick", n, 9);
      te(1'b0, 92, 1, 0);

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
